// File: rtl/tmr_pkg.sv
// Shared definitions for the TMR scrub controller.
//   state_e  : controller FSM states
//   LANE_*   : lane indices used for scrub_lane and per-lane arrays
//   streak_w : width of a streak counter able to hold 0..thresh
package tmr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } state_e;

  localparam logic [1:0] LANE_A = 2'd0;
  localparam logic [1:0] LANE_B = 2'd1;
  localparam logic [1:0] LANE_C = 2'd2;

  function automatic int unsigned streak_w(input int unsigned thresh);
    return $clog2(thresh + 1);
  endfunction

endpackage

// File: rtl/tmr_majority.sv
// Combinational bitwise majority voter for three replica words.
//   a_i, b_i, c_i : replica words
//   vote_o        : bitwise majority
//   mism_o        : bit i set when lane i differs from the vote in any bit
//   multi_o       : two or more lanes disagree with the vote
module tmr_majority #(
  parameter int unsigned DATA_LEN = 16
) (
  input  logic [DATA_LEN-1:0] a_i,
  input  logic [DATA_LEN-1:0] b_i,
  input  logic [DATA_LEN-1:0] c_i,
  output logic [DATA_LEN-1:0] vote_o,
  output logic [2:0]          mism_o,
  output logic                multi_o
);

  always_comb begin
    vote_o    = (a_i & b_i) | (b_i & c_i) | (a_i & c_i);
    mism_o[0] = (a_i != vote_o);
    mism_o[1] = (b_i != vote_o);
    mism_o[2] = (c_i != vote_o);
    multi_o   = (mism_o[0] & mism_o[1]) | (mism_o[1] & mism_o[2]) |
                (mism_o[0] & mism_o[2]);
  end

endmodule

// File: rtl/tmr_scrub_ctrl.sv
// TMR vote / scrub controller.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, a, b, c   : replica sample
//   out_valid, out      : registered majority value
//   mism, multi_err     : registered per-lane disagreement flags
//   scrub_req/lane/data : reload request for a persistently wrong lane
//   scrub_ack           : replica set finished the reload
//   busy                : a scrub is outstanding
//   fault_a/b/c         : saturating count of completed scrubs per lane
module tmr_scrub_ctrl
  import tmr_pkg::*;
#(
  parameter int unsigned DATA_LEN = 16,
  parameter int unsigned THRESH   = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DATA_LEN-1:0] a,
  input  logic [DATA_LEN-1:0] b,
  input  logic [DATA_LEN-1:0] c,
  output logic                out_valid,
  output logic [DATA_LEN-1:0] out,
  output logic [2:0]          mism,
  output logic                multi_err,
  output logic                scrub_req,
  output logic [1:0]          scrub_lane,
  output logic [DATA_LEN-1:0] scrub_data,
  input  logic                scrub_ack,
  output logic                busy,
  output logic [CNT_W-1:0]    fault_a,
  output logic [CNT_W-1:0]    fault_b,
  output logic [CNT_W-1:0]    fault_c
);

  localparam int unsigned   SW    = streak_w(THRESH);
  localparam logic [SW-1:0] S_MAX = SW'(THRESH);
  localparam logic [SW-1:0] S_ARM = SW'(THRESH - 1);

  logic [DATA_LEN-1:0] vote;
  logic [2:0]          m;
  logic                multi;

  tmr_majority #(
    .DATA_LEN(DATA_LEN)
  ) u_vote (
    .a_i    (a),
    .b_i    (b),
    .c_i    (c),
    .vote_o (vote),
    .mism_o (m),
    .multi_o(multi)
  );

  state_e              state_q, state_d;
  logic [SW-1:0]       streak_q [3];
  logic [SW-1:0]       streak_d [3];
  logic [CNT_W-1:0]    fault_q  [3];
  logic [CNT_W-1:0]    fault_d  [3];
  logic [1:0]          lane_q, lane_d;
  logic [DATA_LEN-1:0] sdata_q, sdata_d;
  logic [DATA_LEN-1:0] out_q;
  logic [2:0]          mism_q;
  logic                multi_q;
  logic                ovalid_q;
  logic [2:0]          armed;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    sdata_d = sdata_q;
    armed   = '0;

    for (int unsigned i = 0; i < 3; i++) begin
      streak_d[i] = streak_q[i];
      fault_d[i]  = fault_q[i];
      // Armed when this sample takes the streak to THRESH; a lane already
      // saturated during a scrub stays armed so it fires on return to IDLE.
      armed[i]    = m[i] && (streak_q[i] >= S_ARM);
      if (in_valid) begin
        if (m[i]) begin
          streak_d[i] = (streak_q[i] == S_MAX) ? S_MAX : streak_q[i] + 1'b1;
        end else begin
          streak_d[i] = '0;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (in_valid && !multi && (armed != 3'b000)) begin
          state_d = SCRUB;
          sdata_d = vote;
          if (armed[0])      lane_d = LANE_A;
          else if (armed[1]) lane_d = LANE_B;
          else               lane_d = LANE_C;
        end
      end
      SCRUB: begin
        if (scrub_ack) begin
          state_d = IDLE;
          // Overrides the streak update above: the ack clear wins over a
          // same-cycle mismatch on the scrubbed lane.
          for (int unsigned i = 0; i < 3; i++) begin
            if (lane_q == 2'(i)) begin
              streak_d[i] = '0;
              if (fault_q[i] != '1) fault_d[i] = fault_q[i] + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lane_q   <= '0;
      sdata_q  <= '0;
      out_q    <= '0;
      mism_q   <= '0;
      multi_q  <= 1'b0;
      ovalid_q <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
        streak_q[i] <= '0;
        fault_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      sdata_q  <= sdata_d;
      ovalid_q <= in_valid;
      if (in_valid) begin
        out_q   <= vote;
        mism_q  <= m;
        multi_q <= multi;
      end
      for (int unsigned i = 0; i < 3; i++) begin
        streak_q[i] <= streak_d[i];
        fault_q[i]  <= fault_d[i];
      end
    end
  end

  assign out_valid  = ovalid_q;
  assign out        = out_q;
  assign mism       = mism_q;
  assign multi_err  = multi_q;
  assign scrub_req  = (state_q == SCRUB);
  assign busy       = (state_q == SCRUB);
  assign scrub_lane = lane_q;
  assign scrub_data = sdata_q;
  assign fault_a    = fault_q[LANE_A];
  assign fault_b    = fault_q[LANE_B];
  assign fault_c    = fault_q[LANE_C];

endmodule
